// File: rtl/model_cpu_core.sv
// Top-level compute block of the model computer: editable 4x256-byte program store,
// six registers, PC, RAM, shared call/data stack and single-byte I/O.
module model_cpu_core #(
   parameter int RUN_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rstROM,
   input  logic       NEXT,
   input  logic       RUN,
   input  logic       SPEEDRUN,
   input  logic       edit,
   input  logic [7:0] unit,
   input  logic [7:0] code,
   input  logic       send,
   input  logic [1:0] program_sel,
   input  logic [7:0] I,
   output logic [7:0] O,
   output logic       IEnable,
   output logic       OEnable,
   output logic [7:0] reg0_monitor_signal,
   output logic [7:0] reg1_monitor_signal,
   output logic [7:0] reg2_monitor_signal,
   output logic [7:0] reg3_monitor_signal,
   output logic [7:0] reg4_monitor_signal,
   output logic [7:0] reg5_monitor_signal,
   output logic [7:0] counter_monitor_signal,
   output logic [7:0] O_monitor_signal,
   output logic [1:0] run_state_monitor_signal
);
   localparam int DW = $clog2(RUN_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SLOW = 2'd1, ST_FAST = 2'd2} run_state_e;
   run_state_e state_q, state_d;

   logic [7:0]    prog_mem [1024];
   logic [7:0]    ram [256];
   logic [7:0]    stk [16];
   logic [7:0]    regs [6];
   logic [7:0]    pc, o_q, addr_q;
   logic [3:0]    sp, sp_pop, sp_n;
   logic [DW-1:0] div_cnt;
   logic          next_d, next_dd, run_d, run_dd, spd_d, spd_dd, send_d;

   logic [7:0] op, arg1, arg2, dest, v1, v2, alu_res, pc_n, push_val, stk_top;
   logic [1:0] cls;
   logic [3:0] fn;
   logic       use1, use2, do_pop, i_used, taken, push_en, exec, alu_wr, is_halt;

   assign op      = prog_mem[{program_sel, pc}];
   assign arg1    = prog_mem[{program_sel, pc + 8'd1}];
   assign arg2    = prog_mem[{program_sel, pc + 8'd2}];
   assign dest    = prog_mem[{program_sel, pc + 8'd3}];
   assign stk_top = stk[sp - 4'd1];

   function automatic logic [7:0] src_val(input logic [7:0] c);
      logic [7:0] v;
      v = 8'h00;
      case (c)
         8'h00: v = regs[0];
         8'h01: v = regs[1];
         8'h02: v = regs[2];
         8'h03: v = regs[3];
         8'h04: v = regs[4];
         8'h05: v = regs[5];
         8'h06: v = pc;
         8'h07: v = I;
         8'h10: v = ram[addr_q];
         8'h11: v = addr_q;
         8'h12: v = stk_top;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   // Execution strobe: one instruction retires on each rising edge where exec is high.
   assign exec = !edit && ((state_q == ST_FAST) ||
                           (state_q == ST_SLOW && div_cnt == DIV_LAST) ||
                           (state_q == ST_IDLE && next_d && !next_dd));

   always_comb begin
      cls     = op[5:4];
      fn      = op[3:0];
      v1      = op[7] ? arg1 : src_val(arg1);
      v2      = op[6] ? arg2 : src_val(arg2);
      use1    = (cls == 2'b00) || (cls == 2'b10) || (cls == 2'b11 && fn == 4'd0);
      use2    = (cls == 2'b00) || (cls == 2'b10);
      is_halt = (cls == 2'b11) && (fn == 4'd2);
      // Two stack operands share a single pop; RET pops the return address.
      do_pop  = (use1 && !op[7] && arg1 == 8'h12) || (use2 && !op[6] && arg2 == 8'h12) ||
                (cls == 2'b11 && fn == 4'd1);
      i_used  = (use1 && !op[7] && arg1 == 8'h07) || (use2 && !op[6] && arg2 == 8'h07);
      alu_wr  = exec && (cls == 2'b00);
   end

   always_comb begin
      alu_res = 8'h00;
      case (fn)
         4'd0:  alu_res = v1 + v2;
         4'd1:  alu_res = v1 - v2;
         4'd2:  alu_res = v1 & v2;
         4'd3:  alu_res = v1 | v2;
         4'd4:  alu_res = ~v1;
         4'd5:  alu_res = v1 ^ v2;
         4'd6:  alu_res = (v2 >= 8'd8) ? 8'h00 : v1 << v2[2:0];
         4'd7:  alu_res = (v2 >= 8'd8) ? 8'h00 : v1 >> v2[2:0];
         4'd8:  alu_res = v1 * v2;
         4'd9:  alu_res = (v2 == 8'd0) ? 8'hFF : v1 / v2;
         4'd10: alu_res = (v2 == 8'd0) ? v1 : v1 % v2;
         default: alu_res = 8'h00;
      endcase
      taken = 1'b0;
      case (fn)
         4'd0: taken = (v1 == v2);
         4'd1: taken = (v1 != v2);
         4'd2: taken = (v1 < v2);
         4'd3: taken = (v1 <= v2);
         4'd4: taken = (v1 > v2);
         4'd5: taken = (v1 >= v2);
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      pc_n     = pc + 8'd4;
      push_en  = 1'b0;
      push_val = alu_res;
      case (cls)
         2'b00: begin
            if (dest == 8'h06) pc_n = alu_res;
            if (dest == 8'h12) push_en = 1'b1;
         end
         2'b10: if (taken) pc_n = dest;
         2'b11: begin
            if (fn == 4'd0) begin
               push_en  = 1'b1;
               push_val = pc + 8'd4;
               pc_n     = v1;
            end else if (fn == 4'd1) begin
               pc_n = stk_top;
            end else if (fn == 4'd2) begin
               pc_n = pc;
            end
         end
         default: pc_n = pc + 8'd4;
      endcase
      sp_pop = do_pop ? sp - 4'd1 : sp;
      sp_n   = push_en ? sp_pop + 4'd1 : sp_pop;
   end

   always_comb begin
      state_d = state_q;
      if (edit) state_d = ST_IDLE;
      else if (exec && is_halt) state_d = ST_IDLE;
      else if (run_d && !run_dd) state_d = (state_q == ST_IDLE) ? ST_SLOW : ST_IDLE;
      else if (spd_d && !spd_dd) state_d = (state_q == ST_IDLE) ? ST_FAST : ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         div_cnt <= '0;
         {next_d, next_dd, run_d, run_dd, spd_d, spd_dd, send_d} <= '0;
         for (int i = 0; i < 6; i++) regs[i] <= 8'h00;
         pc     <= 8'h00;
         o_q    <= 8'h00;
         addr_q <= 8'h00;
         sp     <= 4'h0;
      end else begin
         {next_d, next_dd} <= {NEXT, next_d};
         {run_d, run_dd}   <= {RUN, run_d};
         {spd_d, spd_dd}   <= {SPEEDRUN, spd_d};
         send_d            <= send;
         state_q           <= state_d;
         div_cnt <= (state_q != ST_SLOW || div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
         if (exec) begin
            pc <= pc_n;
            sp <= sp_n;
         end
         if (alu_wr) begin
            for (int i = 0; i < 6; i++)
               if (dest == 8'(i)) regs[i] <= alu_res;
            if (dest == 8'h07) o_q <= alu_res;
            if (dest == 8'h11) addr_q <= alu_res;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (alu_wr && dest == 8'h10) ram[addr_q] <= alu_res;
      if (exec && push_en) stk[sp_pop] <= push_val;
   end

   always_ff @(posedge clk or negedge rstROM) begin
      if (!rstROM) begin
         for (int i = 0; i < 1024; i++) prog_mem[i] <= 8'h00;
      end else if (edit && send && !send_d) begin
         prog_mem[{program_sel, unit}] <= code;
      end
   end

   assign O                        = o_q;
   assign O_monitor_signal         = o_q;
   assign OEnable                  = alu_wr && (dest == 8'h07);
   assign IEnable                  = exec && i_used;
   assign counter_monitor_signal   = pc;
   assign reg0_monitor_signal      = regs[0];
   assign reg1_monitor_signal      = regs[1];
   assign reg2_monitor_signal      = regs[2];
   assign reg3_monitor_signal      = regs[3];
   assign reg4_monitor_signal      = regs[4];
   assign reg5_monitor_signal      = regs[5];
   assign run_state_monitor_signal = state_q;
endmodule

// File: tb/tb_model_cpu_core.sv
// Randomised and directed bench for model_cpu_core against an instruction-level reference model.
module tb_model_cpu_core;
   logic       clk = 1'b0;
   logic       rst, rstROM, NEXT, RUN, SPEEDRUN, edit, send;
   logic [7:0] unit, code, I;
   logic [1:0] program_sel;
   logic [7:0] O, r0, r1, r2, r3, r4, r5, pcm, om;
   logic       IEnable, OEnable;
   logic [1:0] run_state;

   always #5 clk = ~clk;

   model_cpu_core #(.RUN_DIV(4)) dut (
      .clk(clk), .rst(rst), .rstROM(rstROM), .NEXT(NEXT), .RUN(RUN), .SPEEDRUN(SPEEDRUN),
      .edit(edit), .unit(unit), .code(code), .send(send), .program_sel(program_sel), .I(I),
      .O(O), .IEnable(IEnable), .OEnable(OEnable),
      .reg0_monitor_signal(r0), .reg1_monitor_signal(r1), .reg2_monitor_signal(r2),
      .reg3_monitor_signal(r3), .reg4_monitor_signal(r4), .reg5_monitor_signal(r5),
      .counter_monitor_signal(pcm), .O_monitor_signal(om), .run_state_monitor_signal(run_state)
   );

   int n_vec = 0, n_fail = 0;
   logic [7:0] exp_q[$];
   logic [7:0] pend;
   bit   pend_v = 1'b0;
   int   ien_seen = 0;

   // Reference model state
   int mem_m [1024];
   int r_m [6];
   int ram_m [256];
   int stk_m [16];
   int pc_m, o_m, addr_m, sp_m, ien_m, prog_bank, cur_i;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] dut_reg(input int i);
      case (i)
         0: return r0;
         1: return r1;
         2: return r2;
         3: return r3;
         4: return r4;
         default: return r5;
      endcase
   endfunction

   task automatic check_state(input string tag);
      for (int i = 0; i < 6; i++) chk($sformatf("%s reg%0d", tag, i), 16'(dut_reg(i)), 16'(r_m[i]));
      chk({tag, " pc"}, 16'(pcm), 16'(pc_m));
      chk({tag, " O"}, 16'(O), 16'(o_m));
      chk({tag, " O_mon"}, 16'(om), 16'(o_m));
   endtask

   task automatic model_reset();
      for (int i = 0; i < 6; i++) r_m[i] = 0;
      pc_m = 0; o_m = 0; addr_m = 0; sp_m = 0;
   endtask

   function automatic int rd_m(input int c);
      if (c < 6) return r_m[c];
      case (c)
         6: return pc_m;
         7: return cur_i;
         16: return ram_m[addr_m];
         17: return addr_m;
         18: return stk_m[(sp_m + 15) % 16];
         default: return 0;
      endcase
   endfunction

   function automatic int alu_m(input int f, input int a, input int b);
      case (f)
         0: return (a + b) % 256;
         1: return (a - b + 256) % 256;
         2: return a & b;
         3: return a | b;
         4: return 255 - a;
         5: return a ^ b;
         6: return (b >= 8) ? 0 : (a << b) % 256;
         7: return (b >= 8) ? 0 : a >> b;
         8: return (a * b) % 256;
         9: return (b == 0) ? 255 : a / b;
         10: return (b == 0) ? a : a % b;
         default: return 0;
      endcase
   endfunction

   // One instruction at the instruction-set level; O writes go to the scoreboard.
   task automatic model_step(output bit halted);
      int base, opc, b1, b2, d, c, f, a, b, top, npc, res;
      bit imm1, imm2, u1, u2, tk;
      base = prog_bank * 256;
      opc = mem_m[base + pc_m];
      b1 = mem_m[base + (pc_m + 1) % 256];
      b2 = mem_m[base + (pc_m + 2) % 256];
      d  = mem_m[base + (pc_m + 3) % 256];
      c = (opc / 16) % 4; f = opc % 16;
      imm1 = (opc >= 128); imm2 = ((opc / 64) % 2) == 1;
      u1 = (c == 0) || (c == 2) || (c == 3 && f == 0);
      u2 = (c == 0) || (c == 2);
      a = imm1 ? b1 : rd_m(b1);
      b = imm2 ? b2 : rd_m(b2);
      if ((u1 && !imm1 && b1 == 7) || (u2 && !imm2 && b2 == 7)) ien_m++;
      top = stk_m[(sp_m + 15) % 16];
      if ((u1 && !imm1 && b1 == 18) || (u2 && !imm2 && b2 == 18) || (c == 3 && f == 1))
         sp_m = (sp_m + 15) % 16;
      npc = (pc_m + 4) % 256;
      halted = 1'b0;
      if (c == 0) begin
         res = alu_m(f, a, b);
         if (d < 6) r_m[d] = res;
         else if (d == 6) npc = res;
         else if (d == 7) begin o_m = res; exp_q.push_back(8'(res)); end
         else if (d == 16) ram_m[addr_m] = res;
         else if (d == 17) addr_m = res;
         else if (d == 18) begin stk_m[sp_m] = res; sp_m = (sp_m + 1) % 16; end
      end else if (c == 2) begin
         tk = (f == 0) ? (a == b) : (f == 1) ? (a != b) : (f == 2) ? (a < b) :
              (f == 3) ? (a <= b) : (f == 4) ? (a > b) : (f == 5) ? (a >= b) : 1'b0;
         if (tk) npc = d;
      end else if (c == 3) begin
         if (f == 0) begin stk_m[sp_m] = npc; sp_m = (sp_m + 1) % 16; npc = a; end
         else if (f == 1) npc = top;
         else if (f == 2) begin npc = pc_m; halted = 1'b1; end
      end
      pc_m = npc;
   endtask

   // Scoreboard monitor: OEnable marks the executing cycle, O is checked one cycle later.
   always @(negedge clk) begin
      if (IEnable === 1'b1) ien_seen++;
      if (pend_v) begin
         chk("o_write", 16'(O), 16'(pend));
         pend_v = 1'b0;
      end
      if (OEnable === 1'b1) begin
         if (exp_q.size() == 0) chk("oenable_unexpected", 16'd1, 16'd0);
         else begin
            pend = exp_q.pop_front();
            pend_v = 1'b1;
         end
      end
   end

   task automatic wr_byte(input int bank, input int a, input int d);
      @(posedge clk); #1;
      edit = 1'b1; program_sel = 2'(bank); unit = 8'(a); code = 8'(d); send = 1'b1;
      @(posedge clk); #1;
      send = 1'b0;
      mem_m[bank * 256 + a] = d;
   endtask

   task automatic wr_word(input int bank, input int a, input logic [31:0] w);
      wr_byte(bank, a, int'(w[31:24]));
      wr_byte(bank, a + 1, int'(w[23:16]));
      wr_byte(bank, a + 2, int'(w[15:8]));
      wr_byte(bank, a + 3, int'(w[7:0]));
   endtask

   task automatic end_edit(input int bank);
      @(posedge clk); #1;
      edit = 1'b0; program_sel = 2'(bank); prog_bank = bank;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic step_next();
      bit h;
      I = 8'(cur_i);
      model_step(h);
      @(posedge clk); #1 NEXT = 1'b1;
      @(posedge clk); #1 NEXT = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   function automatic int pick_src();
      int t;
      t = $urandom_range(0, 9);
      if (t < 8) return t;
      return (t == 8) ? 17 : 42;
   endfunction

   function automatic int pick_dst();
      int t;
      t = $urandom_range(0, 9);
      if (t < 6) return t;
      case (t)
         6: return 7;
         7: return 16;
         8: return 17;
         default: return 19;
      endcase
   endfunction

   int exp_pc [16] = '{4, 8, 12, 16, 64, 68, 128, 72, 76, 80, 84, 88, 92, 96, 100, 100};

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

   initial begin
      bit h;
      int k, ok, c, opc, b1, b2, d;
      rst = 1'b1; rstROM = 1'b1; NEXT = 1'b0; RUN = 1'b0; SPEEDRUN = 1'b0;
      edit = 1'b0; send = 1'b0; unit = 8'h00; code = 8'h00; program_sel = 2'd0; I = 8'h00;
      for (int i = 0; i < 1024; i++) mem_m[i] = 0;
      ien_m = 0; prog_bank = 0; cur_i = 0;
      model_reset();
      #2 rst = 1'b0; rstROM = 1'b0;
      #1;
      check_state("reset");
      chk("reset IEnable", 16'(IEnable), 16'd0);
      chk("reset OEnable", 16'(OEnable), 16'd0);
      #17 rst = 1'b1; rstROM = 1'b1;

      // Fibonacci-style program in bank 0, run in RUN mode until HALT
      wr_word(0, 0,  32'h00070700); wr_word(0, 4,  32'h00000701);
      wr_word(0, 8,  32'h00000102); wr_word(0, 12, 32'h00010203);
      wr_word(0, 16, 32'h00020304); wr_word(0, 20, 32'h00030405);
      wr_word(0, 24, 32'h00000007); wr_word(0, 28, 32'h00000007);
      wr_word(0, 32, 32'h32000000);
      end_edit(0);
      cur_i = 15; I = 8'd15;
      k = 0; h = 1'b0;
      while (!h && k < 100) begin model_step(h); k++; end
      @(posedge clk); #1 RUN = 1'b1;
      @(posedge clk); #1 RUN = 1'b0;
      ok = 0;
      for (int n = 0; n < 400 && ok == 0; n++) begin
         @(posedge clk); #1;
         if (pcm == 8'd32 && run_state == 2'd0) ok = 1;
      end
      chk("run reached halt", 16'(ok), 16'd1);
      repeat (10) @(posedge clk);
      #1;
      check_state("run");
      chk("run reg0 const", 16'(r0), 16'd30);
      chk("run reg5 const", 16'(r5), 16'd59);
      chk("run O const", 16'(O), 16'd60);
      chk("run pc frozen", 16'(pcm), 16'd32);
      chk("halt idle", 16'(run_state), 16'd0);

      // Single stepping the same program
      do_reset();
      check_state("after rst");
      for (int s = 0; s < 3; s++) begin
         step_next();
         check_state($sformatf("step%0d", s));
         chk($sformatf("step%0d pc const", s), 16'(pcm), 16'(4 * (s + 1)));
      end

      // Directed immediates, jumps, call/ret, RAM and stack in bank 2
      wr_word(2, 0, 32'hC1050700);    wr_word(2, 4, 32'hC9090001);
      wr_word(2, 8, 32'hC6010802);    wr_word(2, 12, 32'hCA070003);
      wr_word(2, 16, 32'hE0030340);   wr_word(2, 64, 32'hE2050300);
      wr_word(2, 68, 32'hB0800000);   wr_word(2, 128, 32'h31000000);
      wr_word(2, 72, 32'hC0050011);   wr_word(2, 76, 32'hC04D0010);
      wr_word(2, 80, 32'h40100004);   wr_word(2, 84, 32'hC0090012);
      wr_word(2, 88, 32'hC0040012);   wr_word(2, 92, 32'h01121201);
      wr_word(2, 96, 32'h40120002);   wr_word(2, 100, 32'h32000000);
      end_edit(2);
      do_reset();
      for (int s = 0; s < 16; s++) begin
         step_next();
         check_state($sformatf("dir%0d", s));
         chk($sformatf("dir%0d pc const", s), 16'(pcm), 16'(exp_pc[s]));
         if (s == 0) chk("sub imm const", 16'(r0), 16'hFE);
         if (s == 1) chk("div0 const", 16'(r1), 16'hFF);
         if (s == 2) chk("shl8 const", 16'(r2), 16'h00);
         if (s == 3) chk("mod0 const", 16'(r3), 16'd7);
      end
      chk("ram readback const", 16'(r4), 16'd77);
      chk("single pop const", 16'(r1), 16'd0);
      chk("stack second const", 16'(r2), 16'd9);

      // Random ALU/jump/NOP program in bank 1, stepped with random input bytes
      for (int s = 0; s < 64; s++) begin
         c = $urandom_range(0, 9);
         c = (c < 7) ? 0 : (c < 9) ? 2 : 1;
         opc = c * 16 + $urandom_range(0, 15) + 128 * $urandom_range(0, 1) + 64 * $urandom_range(0, 1);
         b1 = (opc >= 128) ? $urandom_range(0, 255) : pick_src();
         b2 = (((opc / 64) % 2) == 1) ? $urandom_range(0, 255) : pick_src();
         d  = (c == 2) ? 4 * $urandom_range(0, 63) : pick_dst();
         wr_word(1, 4 * s, {8'(opc), 8'(b1), 8'(b2), 8'(d)});
      end
      end_edit(1);
      do_reset();
      for (int s = 0; s < 60; s++) begin
         cur_i = $urandom_range(0, 255);
         step_next();
         check_state($sformatf("rnd%0d", s));
      end

      // Mid-run reset in SPEEDRUN, program retention, program clear, HALT resume
      wr_word(3, 0, 32'h40000100);
      wr_word(3, 4, 32'hE0000000);
      end_edit(3);
      @(posedge clk); #1 SPEEDRUN = 1'b1;
      @(posedge clk); #1 SPEEDRUN = 1'b0;
      repeat ($urandom_range(10, 40)) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      #2;
      check_state("midrun rst");
      chk("midrun IEnable", 16'(IEnable), 16'd0);
      chk("midrun OEnable", 16'(OEnable), 16'd0);
      chk("midrun idle", 16'(run_state), 16'd0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      step_next();
      check_state("retained");
      chk("retained reg0 const", 16'(r0), 16'd1);
      @(posedge clk); #1 rstROM = 1'b0;
      for (int i = 0; i < 1024; i++) mem_m[i] = 0;
      @(posedge clk); #1 rstROM = 1'b1;
      step_next();
      check_state("cleared");
      chk("cleared reg0 const", 16'(r0), 16'd2);
      wr_byte(3, 8, 8'h32);
      end_edit(3);
      step_next();
      check_state("halt step");
      chk("halt pc const", 16'(pcm), 16'd8);
      wr_byte(3, 8, 8'h10);
      end_edit(3);
      step_next();
      check_state("resume");
      chk("resume pc const", 16'(pcm), 16'd12);

      repeat (3) @(posedge clk);
      #1;
      chk("o_queue drained", 16'(exp_q.size() + int'(pend_v)), 16'd0);
      chk("ienable count", 16'(ien_seen), 16'(ien_m));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
